mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single BRAM port A between three requesters: instruction fetch (program counter path), load/store (global_fsm-driven data access) and a debug/IO port.
- Replaces the 2:1 address select between the PC and rdst address with a real arbiter.
- Issues at most one memory access per cycle and routes the 1-cycle-latency read return to the requester that issued the read.
- Guarantees forward progress for low-priority requesters with wait counters.

Parameters:
- ADDR_W, 10, BRAM address width.
- DATA_W, 16, data word width.
- MAX_WAIT, 4, consecutive denied cycles after which a waiting requester is promoted to top priority (valid range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- f_req  input  1  fetch read request.
- f_addr  input  ADDR_W  fetch address.
- f_gnt  output  1  fetch request accepted this cycle.
- f_rvalid  output  1  rdata holds fetch read data.
- ls_req  input  1  load/store request.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  ADDR_W  load/store address.
- ls_wdata  input  DATA_W  store data.
- ls_gnt  output  1  load/store accepted this cycle.
- ls_rvalid  output  1  rdata holds load data.
- dbg_req  input  1  debug request.
- dbg_we  input  1  1 = write, 0 = read.
- dbg_addr  input  ADDR_W  debug address.
- dbg_wdata  input  DATA_W  debug write data.
- dbg_gnt  output  1  debug accepted this cycle.
- dbg_rvalid  output  1  rdata holds debug read data.
- mem_addr  output  ADDR_W  to BRAM addr_a.
- mem_we  output  1  to BRAM we_a.
- mem_wdata  output  DATA_W  to BRAM data_a.
- mem_rdata  input  DATA_W  from BRAM q_a.
- rdata  output  DATA_W  shared read-return bus.
- busy  output  1  an access was granted last cycle or is granted this cycle.

Behaviour:
- **Handshake**
  - A requester holds req, addr, we and wdata stable until it sees gnt high at a rising edge.
  - gnt is combinational, at most one-hot, and lasts one cycle per accepted access.
  - A requester may keep req high after gnt to issue its next access in the following cycle (back-to-back).
- **Issue**
  - In the gnt cycle, mem_addr, mem_we and mem_wdata come combinationally from the winner.
  - With no winner: mem_we = 0, mem_addr = last issued address (registered), mem_wdata = 0.
  - Fetch never writes; mem_we is forced to 0 when fetch wins.
- **Read return**
  - On a granted read, a 2-bit return tag (winner ID) is registered.
  - On the next cycle exactly one of f_rvalid, ls_rvalid or dbg_rvalid is 1.
  - rdata = mem_rdata passes through unregistered.
  - A write produces no rvalid.
  - Read latency = 1 cycle after gnt. Back-to-back reads give one rvalid per cycle.
- **Priority**
  - Base order: ls > fetch > dbg.
  - Wait counters f_wait and dbg_wait (4 bits each) increment while the requester's req = 1 and it is not granted, saturating at MAX_WAIT.
  - A counter clears when its requester is granted or its req = 0.
  - Promotion when a counter equals MAX_WAIT: a promoted requester beats ls. If both are promoted, fetch wins.
  - Worst-case wait: dbg waits at most 2*MAX_WAIT+1 cycles under continuous ls and fetch traffic.
- **Reset**
  - While reset = 1, all gnt outputs are forced to 0 and mem_we = 0.
  - At the edge: wait counters = 0, return tag = none, all rvalid = 0, registered mem_addr = 0, busy = 0.
  - Reset in the cycle after a granted read cancels that rvalid.
- **Boundaries**
  - No requests: idle; busy drops 1 cycle after the last gnt.
  - Simultaneous requests: only the winner is granted; losers see gnt = 0 and retry automatically by holding req.
  - Write then read of the same address in consecutive cycles: the read returns the new data. There is no read-during-write forwarding within a single cycle (one access per cycle).
  - Request deasserted before gnt: it is dropped and its counter clears.
  - Address wrap: none; addresses are used as given.

Test Plan:
- Reset, then f_req = 1, f_addr = 0x005 with BRAM[5] = 0x1234 → f_gnt = 1 in cycle 0; f_rvalid = 1 and rdata = 0x1234 in cycle 1; no other rvalid.
- ls_req, ls_we = 1, ls_addr = 0x010, ls_wdata = 0xBEEF, and f_req all in the same cycle → ls_gnt = 1, mem_we = 1, f_gnt = 0. Next cycle f_gnt = 1. A later ls load of 0x010 returns 0xBEEF with ls_rvalid = 1 only.
- ls_req continuously high, f_req held, MAX_WAIT = 4 → f_gnt asserts on the 5th cycle of waiting. ls resumes the following cycle.
- ls and fetch continuous, dbg_req read at 0x3FF held → dbg_gnt within 9 cycles, then dbg_rvalid = 1 with BRAM[0x3FF] data.
- Back-to-back fetch reads 0x000..0x003 with f_req held → f_gnt on 4 consecutive cycles; f_rvalid on 4 consecutive cycles with data in order.
- ls load granted, reset asserted in the next cycle → ls_rvalid = 0, all gnt = 0, wait counters 0, busy = 0 after the reset edge.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: request/grant, BRAM port A and read-return signals of the shared memory port
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_gnt;
    logic              f_rvalid;
    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    modport slave (
        input  f_req, f_addr, ls_req, ls_we, ls_addr, ls_wdata,
               dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        output f_gnt, f_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid,
               mem_addr, mem_we, mem_wdata, rdata, busy
    );

    modport master (
        output f_req, f_addr, ls_req, ls_we, ls_addr, ls_wdata,
               dbg_req, dbg_we, dbg_addr, dbg_wdata, mem_rdata,
        input  f_gnt, f_rvalid, ls_gnt, ls_rvalid, dbg_gnt, dbg_rvalid,
               mem_addr, mem_we, mem_wdata, rdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares BRAM port A between fetch, load/store and debug with starvation-free priority
module mem_port_arbiter #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {TAG_NONE, TAG_F, TAG_LS, TAG_DBG} tag_t;

    tag_t              win;
    tag_t              tag;
    logic [3:0]        f_wait;
    logic [3:0]        dbg_wait;
    logic [ADDR_W-1:0] addr_q;
    logic              gnt_q;
    logic              f_prom;
    logic              dbg_prom;
    logic              rd;

    assign f_prom   = bus.f_req && f_wait == 4'(MAX_WAIT);
    assign dbg_prom = bus.dbg_req && dbg_wait == 4'(MAX_WAIT);

    // winner: promoted fetch, promoted debug, then base order ls > fetch > dbg; nobody while in reset
    always_comb
        win = reset    ? TAG_NONE :
              f_prom   ? TAG_F    :
              dbg_prom ? TAG_DBG  :
              bus.ls_req  ? TAG_LS  :
              bus.f_req   ? TAG_F   :
              bus.dbg_req ? TAG_DBG : TAG_NONE;

    assign bus.f_gnt   = win == TAG_F;
    assign bus.ls_gnt  = win == TAG_LS;
    assign bus.dbg_gnt = win == TAG_DBG;

    assign bus.mem_we    = win == TAG_LS ? bus.ls_we : win == TAG_DBG ? bus.dbg_we : 1'b0;
    assign bus.mem_addr  = win == TAG_F  ? bus.f_addr  :
                           win == TAG_LS ? bus.ls_addr :
                           win == TAG_DBG ? bus.dbg_addr : addr_q;
    assign bus.mem_wdata = win == TAG_LS ? bus.ls_wdata : win == TAG_DBG ? bus.dbg_wdata : '0;

    assign rd = win == TAG_F || (win == TAG_LS && !bus.ls_we) || (win == TAG_DBG && !bus.dbg_we);

    // rvalid is gated by reset so a reset right after a granted read cancels its return
    assign bus.f_rvalid   = tag == TAG_F   && !reset;
    assign bus.ls_rvalid  = tag == TAG_LS  && !reset;
    assign bus.dbg_rvalid = tag == TAG_DBG && !reset;
    assign bus.rdata      = bus.mem_rdata;
    assign bus.busy       = gnt_q || win != TAG_NONE;

    // wait counters, return tag, last issued address and last-cycle grant flag
    always_ff @(posedge clk) begin
        if (reset) begin
            f_wait   <= '0;
            dbg_wait <= '0;
            tag      <= TAG_NONE;
            addr_q   <= '0;
            gnt_q    <= 1'b0;
        end else begin
            f_wait   <= (bus.f_req && win != TAG_F) ? (f_prom ? f_wait : f_wait + 4'd1) : 4'd0;
            dbg_wait <= (bus.dbg_req && win != TAG_DBG) ? (dbg_prom ? dbg_wait : dbg_wait + 4'd1) : 4'd0;
            tag      <= rd ? win : TAG_NONE;
            addr_q   <= bus.mem_addr;
            gnt_q    <= win != TAG_NONE;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random scoreboard bench for the shared memory port arbiter
module tb_mem_port_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MW = 4;

    typedef struct {
        int          due;
        logic [2:0]  v;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    logic [DW-1:0] bram    [2**AW];
    logic [DW-1:0] ref_mem [2**AW];

    // read-first BRAM port with one cycle read latency
    always @(posedge clk) begin
        bus.mem_rdata <= bram[bus.mem_addr];
        if (bus.mem_we) bram[bus.mem_addr] = bus.mem_wdata;
    end

    exp_t          sb[$];
    int            fw = 0;
    int            dw = 0;
    logic          prev_g = 1'b0;
    logic [AW-1:0] last_a = '0;
    int            win = 0;
    logic [2:0]    sg;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // one clock: predict from the rules, compare the issue side, queue the expected return
    task automatic step();
        int            w;
        logic [2:0]    eg;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        @(negedge clk);
        if (reset) w = 0;
        else if (bus.f_req && fw == MW) w = 1;
        else if (bus.dbg_req && dw == MW) w = 3;
        else if (bus.ls_req) w = 2;
        else if (bus.f_req) w = 1;
        else if (bus.dbg_req) w = 3;
        else w = 0;
        eg  = {w == 3, w == 2, w == 1};
        ewe = w == 2 ? bus.ls_we : w == 3 ? bus.dbg_we : 1'b0;
        ea  = w == 1 ? bus.f_addr : w == 2 ? bus.ls_addr : w == 3 ? bus.dbg_addr : last_a;
        ewd = w == 2 ? bus.ls_wdata : w == 3 ? bus.dbg_wdata : '0;
        sg  = {bus.dbg_gnt, bus.ls_gnt, bus.f_gnt};
        check("gnt", 32'(sg), 32'(eg));
        check("mem_we", 32'(bus.mem_we), 32'(ewe));
        check("mem_wdata", 32'(bus.mem_wdata), 32'(ewd));
        if (!reset) begin
            check("mem_addr", 32'(bus.mem_addr), 32'(ea));
            check("busy", 32'(bus.busy), 32'(prev_g || w != 0));
        end
        if (w != 0 && !ewe) sb.push_back('{cyc + 1, eg, ref_mem[ea]});
        if (ewe) ref_mem[ea] = ewd;
        fw = (reset || !bus.f_req || w == 1) ? 0 : (fw < MW ? fw + 1 : MW);
        dw = (reset || !bus.dbg_req || w == 3) ? 0 : (dw < MW ? dw + 1 : MW);
        last_a = reset ? '0 : ea;
        prev_g = !reset && w != 0;
        win = w;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] mon_rv;
    exp_t       mon_e;

    // monitor: every cycle the rvalid lines must match the queued expectation due now
    initial forever begin
        @(negedge clk);
        mon_rv = {bus.dbg_rvalid, bus.ls_rvalid, bus.f_rvalid};
        if (sb.size() > 0 && sb[0].due == cyc) begin
            mon_e = sb.pop_front();
            if (reset) check("rvalid_rst", 32'(mon_rv), 32'd0);
            else begin
                check("rvalid", 32'(mon_rv), 32'(mon_e.v));
                check("rdata", 32'(bus.rdata), 32'(mon_e.d));
            end
        end else check("rvalid_idle", 32'(mon_rv), 32'd0);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int first;
        int got;
        for (int i = 0; i < 2**AW; i++) begin
            bram[i] = DW'($urandom);
            ref_mem[i] = bram[i];
        end
        bram[5] = 16'h1234;      ref_mem[5] = 16'h1234;
        bram[10'h3FF] = 16'hA5C3; ref_mem[10'h3FF] = 16'hA5C3;
        {bus.f_req, bus.ls_req, bus.ls_we, bus.dbg_req, bus.dbg_we} = '0;
        bus.f_addr = '0; bus.ls_addr = '0; bus.dbg_addr = '0;
        bus.ls_wdata = '0; bus.dbg_wdata = '0;
        @(posedge clk); #1;
        step();
        step();
        reset = 1'b0;
        step();

        // single fetch read of address 5
        bus.f_req = 1'b1; bus.f_addr = 10'h005;
        step();
        bus.f_req = 1'b0;
        step();
        step();

        // store beats fetch, fetch follows, then load sees the stored word
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 10'h010; bus.ls_wdata = 16'hBEEF;
        bus.f_req = 1'b1; bus.f_addr = 10'h001;
        step();
        check("store_wins", 32'(sg), 32'b010);
        bus.ls_req = 1'b0; bus.ls_we = 1'b0;
        step();
        check("fetch_next", 32'(sg), 32'b001);
        bus.f_req = 1'b0;
        bus.ls_req = 1'b1; bus.ls_addr = 10'h010;
        step();
        bus.ls_req = 1'b0;
        step();
        step();

        // continuous ls: fetch is promoted on its 5th waiting cycle
        first = -1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h020;
        bus.f_req = 1'b1; bus.f_addr = 10'h007;
        for (int k = 0; k < 6; k++) begin
            step();
            if (sg[0] && first < 0) begin
                first = k;
                bus.f_req = 1'b0;
            end
            if (sg[1]) bus.ls_addr = AW'($urandom_range(0, 63));
        end
        check("promote_cycle", 32'(first), 32'd4);
        bus.ls_req = 1'b0;
        step();
        step();

        // ls and fetch saturate the port; debug read of 0x3FF still gets through
        got = -1;
        bus.ls_req = 1'b1; bus.f_req = 1'b1;
        bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 10'h3FF;
        for (int k = 0; k < 12 && got < 0; k++) begin
            step();
            if (sg[0]) bus.f_addr = AW'($urandom_range(0, 63));
            if (sg[1]) bus.ls_addr = AW'($urandom_range(0, 63));
            if (sg[2]) begin
                got = k + 1;
                bus.dbg_req = 1'b0;
            end
        end
        check("dbg_latency_ok", 32'(got >= 1 && got <= 2 * MW + 1), 32'd1);
        bus.ls_req = 1'b0; bus.f_req = 1'b0; bus.dbg_req = 1'b0;
        step();
        step();

        // back-to-back fetch reads 0..3
        bus.f_req = 1'b1; bus.f_addr = 10'h000;
        for (int k = 0; k < 4; k++) begin
            step();
            check("b2b_gnt", 32'(sg[0]), 32'd1);
            bus.f_addr = AW'(k + 1);
        end
        bus.f_req = 1'b0;
        step();
        step();

        // reset right after a granted load cancels the return
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 10'h030;
        step();
        bus.ls_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        check("busy_after_reset", 32'(bus.busy), 32'd0);

        // random traffic with occasional drops and resets
        for (int n = 0; n < 2000; n++) begin
            reset = $urandom_range(0, 59) == 0;
            step();
            if (win == 1 || !bus.f_req) begin
                bus.f_req = 1'($urandom_range(0, 1));
                bus.f_addr = AW'($urandom_range(0, 15));
            end else if ($urandom_range(0, 19) == 0) bus.f_req = 1'b0;
            if (win == 2 || !bus.ls_req) begin
                bus.ls_req = 1'($urandom_range(0, 1));
                bus.ls_we = 1'($urandom_range(0, 1));
                bus.ls_addr = AW'($urandom_range(0, 15));
                bus.ls_wdata = DW'($urandom);
            end else if ($urandom_range(0, 19) == 0) bus.ls_req = 1'b0;
            if (win == 3 || !bus.dbg_req) begin
                bus.dbg_req = $urandom_range(0, 3) == 0;
                bus.dbg_we = 1'($urandom_range(0, 1));
                bus.dbg_addr = AW'($urandom_range(0, 15));
                bus.dbg_wdata = DW'($urandom);
            end else if ($urandom_range(0, 19) == 0) bus.dbg_req = 1'b0;
        end
        reset = 1'b0;
        bus.f_req = 1'b0; bus.ls_req = 1'b0; bus.dbg_req = 1'b0;
        step();
        step();
        step();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
